// File: rtl/riscv_ram_1r1w_ctrl.sv
// riscv_ram_1r1w_ctrl: front-end for a 1R1W RAM with registered read data.
// Zero-fills the RAM after reset, arbitrates two byte-enabled writers
// round-robin onto the write port and merges same-cycle write data into
// the read result so a read always returns the newest data.
module riscv_ram_1r1w_ctrl #(
    parameter int ABITS = 10,
    parameter int DBITS = 32,
    localparam int BE   = (DBITS + 7) / 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr0_req_i,
    input  logic [ABITS-1:0] wr0_addr_i,
    input  logic [DBITS-1:0] wr0_data_i,
    input  logic [BE-1:0]    wr0_be_i,
    output logic             wr0_gnt_o,
    input  logic             wr1_req_i,
    input  logic [ABITS-1:0] wr1_addr_i,
    input  logic [DBITS-1:0] wr1_data_i,
    input  logic [BE-1:0]    wr1_be_i,
    output logic             wr1_gnt_o,
    input  logic             rd_req_i,
    input  logic [ABITS-1:0] rd_addr_i,
    output logic             rd_gnt_o,
    output logic             rd_valid_o,
    output logic [DBITS-1:0] rd_data_o,
    output logic             init_done_o,
    output logic [ABITS-1:0] ram_waddr_o,
    output logic [DBITS-1:0] ram_din_o,
    output logic             ram_we_o,
    output logic [BE-1:0]    ram_be_o,
    output logic [ABITS-1:0] ram_raddr_o,
    input  logic [DBITS-1:0] ram_dout_i
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_e;

    state_e           state_q;
    logic [ABITS-1:0] cnt_q;
    logic             rr_q;        // 0: requester 0 wins a tie, 1: requester 1
    logic             rd_valid_q;
    logic [DBITS-1:0] byp_data_q;
    logic [BE-1:0]    byp_be_q;    // all zero when the last read had no bypass

    logic             run, clr, wr_acc, rd_acc, byp_hit;
    logic [DBITS-1:0] byp_mask;

    assign run = (state_q == RUN);
    assign clr = (state_q == CLEAR);

    // Grants are combinational so a write is accepted in its request cycle.
    assign wr0_gnt_o = run & wr0_req_i & (~wr1_req_i | ~rr_q);
    assign wr1_gnt_o = run & wr1_req_i & (~wr0_req_i |  rr_q);
    assign wr_acc    = wr0_gnt_o | wr1_gnt_o;

    // Write port: clear sweep owns it in CLEAR, otherwise the granted writer.
    always_comb begin
        ram_we_o    = 1'b0;
        ram_waddr_o = '0;
        ram_din_o   = '0;
        ram_be_o    = '0;
        if (clr) begin
            ram_we_o    = 1'b1;
            ram_waddr_o = cnt_q;
            ram_be_o    = '1;
        end else if (wr0_gnt_o) begin
            ram_we_o    = 1'b1;
            ram_waddr_o = wr0_addr_i;
            ram_din_o   = wr0_data_i;
            ram_be_o    = wr0_be_i;
        end else if (wr1_gnt_o) begin
            ram_we_o    = 1'b1;
            ram_waddr_o = wr1_addr_i;
            ram_din_o   = wr1_data_i;
            ram_be_o    = wr1_be_i;
        end
    end

    assign rd_gnt_o    = run;
    assign init_done_o = run;
    assign rd_acc      = rd_req_i & run;
    assign ram_raddr_o = run ? rd_addr_i : '0;

    // The RAM returns pre-write data on a same-address collision, so the
    // colliding write lanes are captured and overlaid on the next cycle.
    assign byp_hit = rd_acc & wr_acc & (ram_waddr_o == rd_addr_i);

    for (genvar i = 0; i < DBITS; i++) begin : g_mask
        assign byp_mask[i] = byp_be_q[i/8];
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_valid_q ? ((byp_data_q & byp_mask) | (ram_dout_i & ~byp_mask))
                                   : '0;

    // FSM, clear counter, round-robin pointer and read/bypass pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
        end else begin
            case (state_q)
                IDLE:    state_q <= CLEAR;
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {ABITS{1'b1}}) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
            if (wr0_gnt_o)      rr_q <= 1'b1;
            else if (wr1_gnt_o) rr_q <= 1'b0;
            rd_valid_q <= rd_acc;
            if (byp_hit) byp_data_q <= ram_din_o;
            byp_be_q   <= byp_hit ? ram_be_o : '0;
        end
    end
endmodule

// File: tb/tb_riscv_ram_1r1w_ctrl.sv
// Bench for riscv_ram_1r1w_ctrl: behavioural RAMs, a memory reference model
// and a read scoreboard; one 32-bit instance plus a 30-bit instance for the
// partial top byte lane.
module tb_riscv_ram_1r1w_ctrl;
    localparam int AB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- 32-bit instance ----------------
    logic        w0r, w1r, rq;
    logic [3:0]  w0a, w1a, ra, w0b, w1b;
    logic [31:0] w0d, w1d;
    logic        g0, g1, rg, rv, idn, mwe;
    logic [31:0] rdat, mdin, mdout;
    logic [3:0]  mwa, mbe, mra;

    riscv_ram_1r1w_ctrl #(.ABITS(AB), .DBITS(32)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .wr0_req_i(w0r), .wr0_addr_i(w0a), .wr0_data_i(w0d), .wr0_be_i(w0b), .wr0_gnt_o(g0),
        .wr1_req_i(w1r), .wr1_addr_i(w1a), .wr1_data_i(w1d), .wr1_be_i(w1b), .wr1_gnt_o(g1),
        .rd_req_i(rq), .rd_addr_i(ra), .rd_gnt_o(rg), .rd_valid_o(rv), .rd_data_o(rdat),
        .init_done_o(idn), .ram_waddr_o(mwa), .ram_din_o(mdin), .ram_we_o(mwe),
        .ram_be_o(mbe), .ram_raddr_o(mra), .ram_dout_i(mdout)
    );

    // ---------------- 30-bit instance ----------------
    logic        b_w0r, b_w1r, b_rq;
    logic [3:0]  b_w0a, b_w1a, b_ra, b_w0b, b_w1b;
    logic [29:0] b_w0d, b_w1d;
    logic        b_g0, b_g1, b_rg, b_rv, b_idn, b_mwe;
    logic [29:0] b_rdat, b_mdin, b_mdout;
    logic [3:0]  b_mwa, b_mbe, b_mra;

    riscv_ram_1r1w_ctrl #(.ABITS(AB), .DBITS(30)) u_dut30 (
        .clk_i(clk), .rst_i(rst),
        .wr0_req_i(b_w0r), .wr0_addr_i(b_w0a), .wr0_data_i(b_w0d), .wr0_be_i(b_w0b), .wr0_gnt_o(b_g0),
        .wr1_req_i(b_w1r), .wr1_addr_i(b_w1a), .wr1_data_i(b_w1d), .wr1_be_i(b_w1b), .wr1_gnt_o(b_g1),
        .rd_req_i(b_rq), .rd_addr_i(b_ra), .rd_gnt_o(b_rg), .rd_valid_o(b_rv), .rd_data_o(b_rdat),
        .init_done_o(b_idn), .ram_waddr_o(b_mwa), .ram_din_o(b_mdin), .ram_we_o(b_mwe),
        .ram_be_o(b_mbe), .ram_raddr_o(b_mra), .ram_dout_i(b_mdout)
    );

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = be[i/8] ? n[i] : o[i];
        return r;
    endfunction

    // Behavioural RAMs: read-first, registered read data; start as garbage.
    logic [31:0] mem_a [16] = '{default: 32'hA5A5_A5A5};
    logic [29:0] mem_b [16] = '{default: 30'h2A5A_5A5A};

    always @(posedge clk) begin
        mdout <= mem_a[mra];
        if (mwe) mem_a[mwa] <= merge32(mem_a[mwa], mdin, mbe);
    end

    always @(posedge clk) begin
        b_mdout <= mem_b[b_mra];
        if (b_mwe) mem_b[b_mwa] <= 30'(merge32({2'b00, mem_b[b_mwa]}, {2'b00, b_mdin}, b_mbe));
    end

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] sbq [$];
    logic        m_run = 1'b0;
    logic        exp_rv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock cycle: check combinational outputs, advance the model,
    // cross the edge, then check the read result at the next falling edge.
    task automatic tick(input logic eg0, input logic eg1);
        logic [31:0] w;
        #1;
        chk("wr0_gnt", g0, eg0);
        chk("wr1_gnt", g1, eg1);
        chk("rd_gnt", rg, m_run);
        chk("init_done", idn, m_run);
        if (m_run) begin
            if (eg0) begin
                chk("we0", mwe, 1); chk("waddr0", mwa, w0a);
                chk("din0", mdin, w0d); chk("be0", mbe, w0b);
            end else if (eg1) begin
                chk("we1", mwe, 1); chk("waddr1", mwa, w1a);
                chk("din1", mdin, w1d); chk("be1", mbe, w1b);
            end else begin
                chk("we_idle", {mwe, mwa, mdin, mbe}, 0);
            end
        end
        if (m_run && !rst) begin
            if (eg0)      ref_mem[w0a] = merge32(ref_mem[w0a], w0d, w0b);
            else if (eg1) ref_mem[w1a] = merge32(ref_mem[w1a], w1d, w1b);
            if (rq) sbq.push_back(ref_mem[ra]);
        end
        exp_rv = m_run && !rst && rq;
        @(posedge clk);
        @(negedge clk);
        chk("rd_valid", rv, exp_rv);
        if (exp_rv && rv) begin
            w = sbq.pop_front();
            chk("rd_data", rdat, w);
        end else if (!rv) begin
            chk("rd_data_zero", rdat, 0);
        end
    endtask

    // Starts at a falling edge with the DUT in IDLE and rst just released.
    // Checks the sweep; if abort_at is reached, pulses rst on that cycle.
    task automatic sweep(input int abort_at);
        #1;
        chk("idle_we", mwe, 0);
        chk("idle_done", idn, 0);
        tick(0, 0);
        for (int k = 0; k < 16; k++) begin
            chk("clr_we", mwe, 1);
            chk("clr_addr", mwa, k);
            chk("clr_din", mdin, 0);
            chk("clr_be", mbe, 4'hF);
            chk("clr_done", idn, 0);
            if (k == abort_at) begin
                rst = 1'b1;
                tick(0, 0);
                rst = 1'b0;
                return;
            end
            tick(0, 0);
        end
        m_run = 1'b1;
        for (int k = 0; k < 16; k++) ref_mem[k] = 32'h0;
    endtask

    typedef struct {
        logic        r0, r1;
        logic [3:0]  a0, a1, b0, b1;
        logic [31:0] d0, d1;
        logic        eg0, eg1;
    } vec_t;

    vec_t tab [10];

    function automatic vec_t mk(input logic r0, input logic r1, input logic e0,
                                input logic e1, input int i);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.eg0 = e0; v.eg1 = e1;
        v.a0 = 4'(8 + i % 4);
        v.a1 = 4'(12 + i % 4);
        v.d0 = $urandom;
        v.d1 = $urandom;
        v.b0 = 4'hF;
        v.b1 = (i % 2 != 0) ? 4'b1010 : 4'b0110;
        return v;
    endfunction

    initial begin
        // Arbitration vectors, starting from pointer = requester 0.
        tab[0] = mk(1, 1, 1, 0, 0);
        tab[1] = mk(1, 1, 0, 1, 1);
        tab[2] = mk(1, 1, 1, 0, 2);
        tab[3] = mk(1, 1, 0, 1, 3);
        tab[4] = mk(0, 1, 0, 1, 4);
        tab[5] = mk(0, 1, 0, 1, 5);
        tab[6] = mk(1, 1, 1, 0, 6);
        tab[7] = mk(0, 0, 0, 0, 7);
        tab[8] = mk(1, 0, 1, 0, 8);
        tab[9] = mk(1, 1, 0, 1, 9);

        w0r = 0; w1r = 0; rq = 0; w0a = 0; w1a = 0; ra = 0;
        w0d = 0; w1d = 0; w0b = 0; w1b = 0;
        b_w0r = 0; b_w1r = 0; b_rq = 0; b_w0a = 0; b_w1a = 0; b_ra = 0;
        b_w0d = 0; b_w1d = 0; b_w0b = 0; b_w1b = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", {g0, g1, rg, rv, idn, mwe}, 0);
        chk("rst_data", rdat, 0);
        chk("rst_ram", {mwa, mdin, mbe, mra}, 0);
        chk("rst_b_done", b_idn, 0);

        // Sweep with every requester active: all must be ignored.
        w0r = 1; w1r = 1; rq = 1; ra = 0;
        rst = 0;
        sweep(-1);
        chk("b_done", b_idn, 1);
        w0r = 0; w1r = 0;

        // Read the whole array back-to-back: all zero.
        for (int k = 0; k < 16; k++) begin
            rq = 1; ra = 4'(k);
            tick(0, 0);
        end
        rq = 0;

        // Arbitration table
        for (int i = 0; i < 10; i++) begin
            w0r = tab[i].r0; w0a = tab[i].a0; w0d = tab[i].d0; w0b = tab[i].b0;
            w1r = tab[i].r1; w1a = tab[i].a1; w1d = tab[i].d1; w1b = tab[i].b1;
            rq = 1; ra = 4'(8 + i % 8);
            tick(tab[i].eg0, tab[i].eg1);
        end
        w0r = 0; w1r = 0;
        for (int k = 8; k < 16; k++) begin
            rq = 1; ra = 4'(k);
            tick(0, 0);
        end
        rq = 0;

        // RAW bypass on addr 5; 30-bit top-lane write on addr 2 alongside.
        w0r = 1; w0a = 5; w0d = 32'h1122_3344; w0b = 4'hF;
        tick(1, 0);
        w0d = 32'hDEAD_BEEF; w0b = 4'b0011; rq = 1; ra = 5;
        b_w0r = 1; b_w0a = 2; b_w0d = 30'h3FFF_FFFF; b_w0b = 4'b1000;
        #1 chk("b_gnt", b_g0, 1);
        tick(1, 0);
        chk("raw_merge", rdat, 32'h1122_BEEF);
        w0r = 0; b_w0r = 0; b_rq = 1; b_ra = 2;
        tick(0, 0);
        chk("raw_reread", rdat, 32'h1122_BEEF);
        chk("b_valid", b_rv, 1);
        chk("b_toplane", b_rdat, 30'h3F00_0000);
        b_rq = 0;
        // Write the next cycle: the pending read result must not change.
        rq = 0; w1r = 1; w1a = 5; w1d = 32'hCAFE_F00D; w1b = 4'hF;
        #1 chk("raw_hold", rdat, 32'h1122_BEEF);
        tick(0, 1);
        w1r = 0; rq = 1; ra = 5;
        tick(0, 0);
        chk("raw_after", rdat, 32'hCAFE_F00D);

        // Reset mid-RUN with a read in the reset cycle: no rd_valid.
        rq = 1; ra = 3; rst = 1;
        tick(0, 0);
        m_run = 0;
        rst = 0;
        // Reset again mid-CLEAR at address 9, then a full sweep.
        sweep(9);
        chk("abort_done", idn, 0);
        sweep(-1);
        rq = 1; ra = 5;
        tick(0, 0);
        chk("cleared5", rdat, 0);
        rq = 0;
        tick(0, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard cycle limit so the bench always terminates.
    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/riscv_ram_1r1w_ctrl.md
# riscv_ram_1r1w_ctrl

Controller placed in front of the inferrable one-read/one-write RAM used by the MPSoC-RISCV memory subsystem. After reset it clears every RAM word to zero. It then arbitrates two byte-enabled write requesters round-robin onto the single write port and serves one read port. Because the RAM itself has no bypass, the controller merges same-cycle write data into the read result so that reads always return the newest data.

## Interface
- ABITS, 10, RAM address width; depth = 2**ABITS words
- DBITS, 32, data width; byte-enable width BE = (DBITS+7)/8, top lane partial when DBITS is not a multiple of 8
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset; synchronous, active-high
- wr0_req_i / wr1_req_i  in  1  write request, requester 0 / 1
- wr0_addr_i / wr1_addr_i  in  ABITS  write address
- wr0_data_i / wr1_data_i  in  DBITS  write data
- wr0_be_i / wr1_be_i  in  BE  byte enables
- wr0_gnt_o / wr1_gnt_o  out  1  write grant; combinational, a write is accepted when req&gnt
- rd_req_i  in  1  read request
- rd_addr_i  in  ABITS  read address
- rd_gnt_o  out  1  read grant; 1 only in state RUN
- rd_valid_o  out  1  read data valid, one cycle after an accepted read
- rd_data_o  out  DBITS  read data; 0 whenever rd_valid_o=0
- init_done_o  out  1  clear sweep complete (state RUN)
- ram_waddr_o / ram_din_o / ram_we_o / ram_be_o  out  ABITS/DBITS/1/BE  RAM write side
- ram_raddr_o  out  ABITS  RAM read address
- ram_dout_i  in  DBITS  RAM registered read data, one-cycle latency

## Operation
- FSM: IDLE -> CLEAR -> RUN. rst_i=1 forces IDLE, clear counter 0, RR pointer to requester 0, rd_valid_o 0.
- IDLE: all outputs 0. Lasts exactly one cycle after rst_i deasserts, then CLEAR.
- CLEAR: ram_we_o=1, ram_be_o all ones, ram_din_o=0, ram_waddr_o=counter. The counter increments each cycle. When counter = 2**ABITS-1 the FSM goes to RUN and the counter wraps to 0. All grants are 0.
- RUN: init_done_o=1 and rd_gnt_o=1.
- Write arbitration:
  - Only one requester active: it is granted.
  - Both requesters active: the one selected by the RR pointer is granted.
  - After any accepted write, the pointer moves to the other requester.
  - At most one grant per cycle.
- Accepted write: ram_we_o=1 and ram_waddr_o/ram_din_o/ram_be_o come from the granted requester in the same cycle. With no accepted write, ram_we_o=0 and the other write outputs are 0.
- Read: ram_raddr_o=rd_addr_i combinationally. An accepted read sets rd_valid_o=1 on the next cycle.
- RAW bypass: if a write is accepted in the same cycle as a read to the same address, the controller registers the write data and byte enables. On the next cycle, for each lane, rd_data_o lane = registered data where the enable is set, else ram_dout_i. Otherwise rd_data_o=ram_dout_i.
- A write in the cycle after a read never affects that read's data.
- A new read may be accepted every cycle, back-to-back.

## Timing
- Reset values: all grants 0, rd_valid_o 0, rd_data_o 0, init_done_o 0, ram_we_o 0, all RAM outputs 0.
- Clear sweep: cycle 0 after reset release is IDLE; cycles 1..2**ABITS are CLEAR; RUN begins at cycle 2**ABITS+1.
- Write: zero-cycle grant; RAM is written at the end of the accept cycle.
- Read latency: 1 cycle from accept to rd_valid_o/rd_data_o.
- rst_i mid-CLEAR or mid-RUN: the next cycle is IDLE and the sweep restarts from address 0. A read accepted in the reset cycle produces no rd_valid_o.
- Requests while not in RUN are ignored and not queued; requesters hold req until granted.

## Test plan
- ABITS=4, DBITS=32: release reset -> 1 IDLE cycle, then ram_we_o=1 for 16 cycles with addresses 0..15 and data 0. init_done_o rises at cycle 17; reads of addresses 0..15 return 0.
- Read during CLEAR: rd_req_i=1 -> rd_gnt_o=0 and no rd_valid_o; first grant occurs at the first RUN cycle.
- Both writers requesting continuously -> grants alternate 0,1,0,1 starting with 0. Only wr1 requesting -> granted every cycle; a following two-way tie then grants 0.
- RAW bypass: addr 5 holds 0x11223344; in one cycle, write 0xDEADBEEF be=0011 to addr 5 and read addr 5 -> next cycle rd_data_o=0x1122BEEF; a re-read returns 0x1122BEEF.
- DBITS=30, be=1000, data 0x3FFFFFFF to addr 2 (previously 0) -> reading addr 2 returns 0x3F000000.
- rst_i pulsed at CLEAR address 9 -> one IDLE cycle, then the sweep restarts at 0; init_done_o stays 0 until the full sweep completes.
